// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a hardware return-address stack.
// In RUN it steps the pc, takes branches, and handles calls/returns.
// A taken redirect spends one cycle in FLUSH; a stack overflow or underflow
// parks the block in ERR until clr_err is raised.
module pc_sequencer #(
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        br_valid,
    input  logic        pcflag,
    input  logic        fcall,
    input  logic        fcallend,
    input  logic [15:0] target,
    input  logic        clr_err,
    output logic [15:0] pc,
    output logic        flush,
    output logic        err,
    output logic [4:0]  ras_depth,
    output logic        ras_full,
    output logic        ras_empty
);

    localparam int unsigned IdxW     = $clog2(RAS_DEPTH);
    localparam logic [4:0]  DepthMax = 5'(RAS_DEPTH);

    typedef enum logic [1:0] {StRun, StFlush, StErr} state_e;

    state_e          state_q, state_d;
    logic [15:0]     pc_q, pc_d;
    logic [4:0]      depth_q, depth_d;
    logic [15:0]     stack_q [RAS_DEPTH];
    logic            push_en;
    logic [IdxW-1:0] push_idx;
    logic [IdxW-1:0] pop_idx;
    logic            stack_full;
    logic            stack_empty;

    assign stack_full  = (depth_q == DepthMax);
    assign stack_empty = (depth_q == 5'd0);
    // Push lands on the first free slot; pop reads the current top.
    assign push_idx    = depth_q[IdxW-1:0];
    assign pop_idx     = IdxW'(depth_q - 5'd1);

    // Next-state, next-pc and stack-control decisions.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        push_en = 1'b0;
        unique case (state_q)
            StRun: begin
                if (en) begin
                    if (!br_valid) begin
                        pc_d = pc_q + 16'd1;
                    end else if (fcall) begin
                        if (stack_full) begin
                            state_d = StErr;
                        end else begin
                            push_en = 1'b1;
                            pc_d    = target;
                            depth_d = depth_q + 5'd1;
                            state_d = StFlush;
                        end
                    end else if (fcallend) begin
                        if (stack_empty) begin
                            state_d = StErr;
                        end else begin
                            pc_d    = stack_q[pop_idx];
                            depth_d = depth_q - 5'd1;
                            state_d = StFlush;
                        end
                    end else if (pcflag) begin
                        pc_d    = target;
                        state_d = StFlush;
                    end else begin
                        // Branch present but not taken.
                        pc_d = pc_q + 16'd1;
                    end
                end
            end
            StFlush: begin
                state_d = StRun;
            end
            StErr: begin
                if (clr_err) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // State, pc and stack depth registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            pc_q    <= 16'h0000;
            depth_q <= 5'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
        end
    end

    // Stack storage; reset only clears the depth, so contents need no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_q + 16'd1;
        end
    end

    assign pc        = pc_q;
    assign flush     = (state_q == StFlush);
    assign err       = (state_q == StErr);
    assign ras_depth = depth_q;
    assign ras_full  = stack_full;
    assign ras_empty = stack_empty;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer against a queue-based model.
module tb_pc_sequencer;

    localparam int RAS = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        br_valid = 1'b0;
    logic        pcflag = 1'b0;
    logic        fcall = 1'b0;
    logic        fcallend = 1'b0;
    logic [15:0] target = 16'h0;
    logic        clr_err = 1'b0;
    logic [15:0] pc;
    logic        flush;
    logic        err;
    logic [4:0]  ras_depth;
    logic        ras_full;
    logic        ras_empty;
    logic [24:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: pc value, a queue as the stack, two mode flags.
    logic [15:0] m_pc;
    logic [15:0] m_stack [$];
    bit          m_flush;
    bit          m_err;

    pc_sequencer #(.RAS_DEPTH(RAS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .br_valid  (br_valid),
        .pcflag    (pcflag),
        .fcall     (fcall),
        .fcallend  (fcallend),
        .target    (target),
        .clr_err   (clr_err),
        .pc        (pc),
        .flush     (flush),
        .err       (err),
        .ras_depth (ras_depth),
        .ras_full  (ras_full),
        .ras_empty (ras_empty)
    );

    always #5 clk = ~clk;

    assign obs = {pc, flush, err, ras_depth, ras_full, ras_empty};

    function automatic logic [24:0] exp_vec();
        int n = m_stack.size();
        return {m_pc, m_flush, m_err, 5'(n), 1'(n == RAS), 1'(n == 0)};
    endfunction

    function automatic void model_reset();
        m_pc = 16'h0;
        m_stack.delete();
        m_flush = 0;
        m_err = 0;
    endfunction

    function automatic void model_step(bit e, bit bv, bit pf, bit fc, bit fe,
                                       logic [15:0] tg, bit ce);
        if (m_flush) begin
            m_flush = 0;
        end else if (m_err) begin
            if (ce) m_err = 0;
        end else if (e) begin
            if (bv && fc) begin
                if (m_stack.size() == RAS) m_err = 1;
                else begin
                    m_stack.push_back(m_pc + 16'd1);
                    m_pc = tg;
                    m_flush = 1;
                end
            end else if (bv && fe) begin
                if (m_stack.size() == 0) m_err = 1;
                else begin
                    m_pc = m_stack.pop_back();
                    m_flush = 1;
                end
            end else if (bv && pf) begin
                m_pc = tg;
                m_flush = 1;
            end else begin
                m_pc = m_pc + 16'd1;
            end
        end
    endfunction

    // Drive one cycle of inputs, advance the model, sample 1ns after the edge.
    task automatic step(input bit e, input bit bv, input bit pf, input bit fc, input bit fe,
                        input logic [15:0] tg, input bit ce);
        en = e; br_valid = bv; pcflag = pf; fcall = fc; fcallend = fe;
        target = tg; clr_err = ce;
        @(posedge clk);
        model_step(e, bv, pf, fc, fe, tg, ce);
        #1;
    endtask

    task automatic apply_reset();
        en = 0; br_valid = 0; pcflag = 0; fcall = 0; fcallend = 0; clr_err = 0;
        rst_n = 0;
        #2;
        model_reset();
        n_checks++;
        if (obs !== 25'({16'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1})) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs,
                     25'({16'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1}));
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        step(0, 1, 1, 0, 0, 16'h1234, 0);
        n_checks++;
        if (pc !== 16'h0000) begin
            n_fail++; $display("FAIL en_low_hold: got %h want 0000", pc);
        end
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 0, 0, 0, 16'h0, 0);
            n_checks++;
            if (obs !== exp_vec() || pc !== 16'(i) || flush !== 1'b0 || ras_empty !== 1'b1) begin
                n_fail++; $display("FAIL seq_inc_%0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_branch();
        apply_reset();
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 16'h0, 0);
        step(1, 1, 1, 0, 0, 16'h0040, 0);
        n_checks++;
        if (pc !== 16'h0040 || flush !== 1'b1 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL branch_taken: got %h want %h", obs, exp_vec());
        end
        step(0, 1, 1, 1, 0, 16'h0999, 0);  // flush ignores en and flags
        n_checks++;
        if (pc !== 16'h0040 || flush !== 1'b0 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL branch_flush_end: got %h want %h", obs, exp_vec());
        end
        step(1, 0, 0, 0, 0, 16'h0, 0);
        n_checks++;
        if (pc !== 16'h0041) begin
            n_fail++; $display("FAIL branch_next: got %h want 0041", pc);
        end
        step(1, 1, 0, 0, 0, 16'h0777, 0);  // not taken
        n_checks++;
        if (pc !== 16'h0042 || flush !== 1'b0) begin
            n_fail++; $display("FAIL branch_not_taken: got %h want 0042", pc);
        end
    endtask

    task automatic test_call_return();
        apply_reset();
        for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0, 16'h0, 0);
        step(1, 1, 0, 1, 0, 16'h0100, 0);
        n_checks++;
        if (pc !== 16'h0100 || ras_depth !== 5'd1 || flush !== 1'b1) begin
            n_fail++; $display("FAIL call: got %h want %h", obs, exp_vec());
        end
        step(1, 0, 0, 0, 0, 16'h0, 0);
        step(1, 0, 0, 0, 0, 16'h0, 0);
        step(1, 1, 0, 0, 1, 16'h0555, 0);
        n_checks++;
        if (pc !== 16'h0021 || ras_depth !== 5'd0 || flush !== 1'b1) begin
            n_fail++; $display("FAIL return: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_overflow();
        logic [15:0] tg [RAS];
        logic [15:0] want;
        apply_reset();
        for (int i = 0; i < RAS; i++) begin
            tg[i] = 16'h1000 + 16'(i * 16'h10);
            step(1, 1, 0, 1, 0, tg[i], 0);
            step(1, 0, 0, 0, 0, 16'h0, 0);  // flush cycle
        end
        step(1, 1, 0, 1, 0, 16'h2222, 0);
        n_checks++;
        if (err !== 1'b1 || ras_full !== 1'b1 || pc !== tg[RAS-1] || obs !== exp_vec()) begin
            n_fail++; $display("FAIL overflow: got %h want %h", obs, exp_vec());
        end
        step(1, 1, 1, 1, 1, 16'h3333, 0);
        n_checks++;
        if (err !== 1'b1 || pc !== tg[RAS-1]) begin
            n_fail++; $display("FAIL err_hold: got %h want %h", obs, exp_vec());
        end
        step(0, 0, 0, 0, 0, 16'h0, 1);
        n_checks++;
        if (err !== 1'b0 || ras_depth !== 5'(RAS) || obs !== exp_vec()) begin
            n_fail++; $display("FAIL clr_err: got %h want %h", obs, exp_vec());
        end
        for (int i = RAS - 1; i >= 0; i--) begin
            want = (i == 0) ? 16'h0001 : tg[i-1] + 16'd1;
            step(1, 1, 0, 0, 1, 16'h0, 0);
            n_checks++;
            if (pc !== want || ras_depth !== 5'(i) || obs !== exp_vec()) begin
                n_fail++; $display("FAIL unwind_%0d: got %h want pc %h", i, obs, want);
            end
            step(1, 0, 0, 0, 0, 16'h0, 0);
        end
    endtask

    task automatic test_underflow_priority();
        apply_reset();
        step(1, 1, 0, 0, 1, 16'h0abc, 0);
        n_checks++;
        if (err !== 1'b1 || pc !== 16'h0000 || ras_empty !== 1'b1) begin
            n_fail++; $display("FAIL underflow: got %h want %h", obs, exp_vec());
        end
        step(1, 0, 0, 0, 0, 16'h0, 1);
        step(1, 1, 1, 1, 1, 16'h0500, 0);
        n_checks++;
        if (pc !== 16'h0500 || ras_depth !== 5'd1 || flush !== 1'b1 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL call_priority: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_wrap_and_async_reset();
        apply_reset();
        step(1, 1, 1, 0, 0, 16'hfffe, 0);
        step(1, 0, 0, 0, 0, 16'h0, 0);
        step(1, 0, 0, 0, 0, 16'h0, 0);
        step(1, 0, 0, 0, 0, 16'h0, 0);
        n_checks++;
        if (pc !== 16'h0000 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL pc_wrap: got %h want 0000", pc);
        end
        step(1, 1, 0, 1, 0, 16'h4444, 0);
        #2;
        rst_n = 0;
        #1;
        n_checks++;
        if (pc !== 16'h0000 || flush !== 1'b0 || ras_empty !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_flush: got %h want pc 0000 flush 0", obs);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_random();
        bit e, bv, pf, fc, fe, ce;
        logic [15:0] tg;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            e  = ($urandom_range(0, 9) < 8);
            bv = ($urandom_range(0, 9) < 5);
            pf = ($urandom_range(0, 9) < 4);
            fc = ($urandom_range(0, 9) < 3);
            fe = ($urandom_range(0, 9) < 4);
            ce = ($urandom_range(0, 9) < 3);
            tg = 16'($urandom);
            step(e, bv, pf, fc, fe, tg, ce);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random_%0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_branch();
        test_call_return();
        test_overflow();
        test_underflow_priority();
        test_wrap_and_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
